// File: rtl/channel_in_acc_tree.sv
// channel_in_acc_tree
//
// Pipelined channel-reduction adder tree with multi-pass accumulation.
// Each beat carries CHANNEL_IN_NUM channel partial products for LANE_NUM
// picture lanes. A log2(CHANNEL_IN_NUM)-stage registered tree adds them per
// lane. An accumulator stage then adds successive tree results, so layers with
// more input channels than CHANNEL_IN_NUM are reduced over several beats
// (first_pass .. last_pass).
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   data_in        channel c, lane p at [(c*LANE_NUM+p)*DATA_WIDTH +: DATA_WIDTH]
//   data_in_valid  beat present this cycle
//   first_pass     beat opens an accumulation group (qualified by valid)
//   last_pass      beat closes the group (qualified by valid)
//   data_out       lane p at [p*DATA_WIDTH +: DATA_WIDTH]; holds between pulses
//   data_out_valid one-cycle pulse when a group sum is presented
//
// Latency from the last_pass beat to data_out_valid is log2(CHANNEL_IN_NUM)+1.
//
// Build option:
//   ACC_SAT_EN  when defined, the accumulator add saturates per lane to the
//               signed DATA_WIDTH range; otherwise it wraps. Tree adds always wrap.

`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef WIDTH_DATA_OUT
`define WIDTH_DATA_OUT 16
`endif

module channel_in_acc_tree #(
  parameter int CHANNEL_IN_NUM = 32,
  parameter int LANE_NUM       = `PICTURE_NUM,
  parameter int DATA_WIDTH     = `WIDTH_DATA_OUT*2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [CHANNEL_IN_NUM*LANE_NUM*DATA_WIDTH-1:0] data_in,
  input  logic                                     data_in_valid,
  input  logic                                     first_pass,
  input  logic                                     last_pass,
  output logic [LANE_NUM*DATA_WIDTH-1:0]           data_out,
  output logic                                     data_out_valid
);

  localparam int CH = CHANNEL_IN_NUM;
  localparam int LN = LANE_NUM;
  localparam int DW = DATA_WIDTH;
  localparam int S  = $clog2(CHANNEL_IN_NUM);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Leaves of the tree: the raw channel values of the current beat, per lane.
  logic [DW-1:0] leaf [LN][CH];

  // Tree nodes in heap order: node k adds children 2k and 2k+1. Children with
  // index >= CH are leaves. Nodes at the same heap depth form one pipeline
  // stage, so node 1 (the root) holds the full sum S cycles after the beat.
  logic [DW-1:0] node_q [LN][1:CH-1];

  for (genvar p = 0; p < LN; p++) begin : gLane
    for (genvar c = 0; c < CH; c++) begin : gLeaf
      assign leaf[p][c] = data_in[(c*LN+p)*DW +: DW];
    end

    // Every node registers the wrap-around sum of its two children each
    // cycle; data is not qualified, the flag pipeline decides what counts.
    for (genvar k = 1; k < CH; k++) begin : gNode
      if (2*k >= CH) begin : gFromLeaf
        always_ff @(posedge clk) begin
          node_q[p][k] <= leaf[p][2*k-CH] + leaf[p][2*k+1-CH];
        end
      end else begin : gFromNode
        always_ff @(posedge clk) begin
          node_q[p][k] <= node_q[p][2*k] + node_q[p][2*k+1];
        end
      end
    end
  end

  // Flag pipeline running alongside the tree. first/last are stored already
  // qualified by valid so a stray flag on an idle cycle never leaks through.
  logic [S-1:0] vld_q;
  logic [S-1:0] fst_q;
  logic [S-1:0] lst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q[0] <= data_in_valid;
      fst_q[0] <= data_in_valid & first_pass;
      lst_q[0] <= data_in_valid & last_pass;
      for (int i = 1; i < S; i++) begin
        vld_q[i] <= vld_q[i-1];
        fst_q[i] <= fst_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
    end
  end

  logic tvalid;
  logic tfirst;
  logic tlast;

  assign tvalid = vld_q[S-1];
  assign tfirst = fst_q[S-1];
  assign tlast  = lst_q[S-1];

  // Accumulator add: saturating or wrapping depending on the build.
  function automatic logic [DW-1:0] accAdd(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
`ifdef ACC_SAT_EN
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    // Overflow when the extended sign disagrees with the result sign.
    if (s[DW] != s[DW-1]) begin
      accAdd = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      accAdd = s[DW-1:0];
    end
`else
    accAdd = a + b;
`endif
  endfunction

  state_t                state_q;
  state_t                state_d;
  logic [LN*DW-1:0]      acc_q;
  logic [LN*DW-1:0]      acc_d;
  logic [LN*DW-1:0]      out_q;
  logic [LN*DW-1:0]      out_d;
  logic                  outValid_q;
  logic                  outValid_d;
  logic [LN*DW-1:0]      newAcc;

  // Value the accumulator takes if the tree beat is valid: a beat arriving
  // while idle, or flagged first, restarts the group from the tree sum.
  always_comb begin
    newAcc = '0;
    for (int p = 0; p < LN; p++) begin
      if ((state_q == ST_IDLE) || tfirst) begin
        newAcc[p*DW +: DW] = node_q[p][1];
      end else begin
        newAcc[p*DW +: DW] = accAdd(acc_q[p*DW +: DW], node_q[p][1]);
      end
    end
  end

  // Accumulator FSM next-state and outputs. A last beat presents the new
  // accumulated value and closes the group; without a beat everything holds.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_d      = out_q;
    outValid_d = 1'b0;
    if (tvalid) begin
      acc_d   = newAcc;
      state_d = ST_RUN;
      if (tlast) begin
        out_d      = newAcc;
        outValid_d = 1'b1;
        state_d    = ST_IDLE;
      end
    end
  end

  // Accumulator state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      out_q      <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      outValid_q <= outValid_d;
    end
  end

  assign data_out       = out_q;
  assign data_out_valid = outValid_q;

endmodule

// File: tb/tb_channel_in_acc_tree.sv
// Testbench for channel_in_acc_tree with CHANNEL_IN_NUM=32, LANE_NUM=2,
// DATA_WIDTH=32. Directed scenarios check literal sums; a randomized run is
// checked against a group-level reference model.

module tb_channel_in_acc_tree;

  localparam int CH  = 32;
  localparam int LN  = 2;
  localparam int DW  = 32;
  localparam int S   = 5;
  localparam int LAT = S + 1;
  localparam int W   = CH*LN*DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    data_in;
  logic            data_in_valid;
  logic            first_pass;
  logic            last_pass;
  logic [LN*DW-1:0] data_out;
  logic            data_out_valid;

  channel_in_acc_tree #(
    .CHANNEL_IN_NUM(CH),
    .LANE_NUM(LN),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .first_pass(first_pass),
    .last_pass(last_pass),
    .data_out(data_out),
    .data_out_valid(data_out_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int               cyc;
    logic [LN*DW-1:0] val;
  } pulse_t;

  pulse_t gotQ[$];
  pulse_t expQ[$];
  pulse_t monPt;

  // Reference model state: whether a group is open and its running sum.
  bit               mOpen = 1'b0;
  logic [LN*DW-1:0] mAcc  = '0;

  // Count rising edges and record every output pulse shortly after the edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (data_out_valid === 1'b1) begin
      monPt.cyc = cyc;
      monPt.val = data_out;
      gotQ.push_back(monPt);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: still running at time %0t, limit 200000", $time);
    $fatal(1);
  end

  function automatic logic [DW-1:0] refAccAdd(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
`ifdef ACC_SAT_EN
    longint s;
    longint maxV;
    longint minV;
    maxV = (longint'(1) <<< (DW-1)) - 1;
    minV = -(longint'(1) <<< (DW-1));
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > maxV) s = maxV;
    if (s < minV) s = minV;
    return s[DW-1:0];
`else
    return a + b;
`endif
  endfunction

  // Drive one beat (called just after a falling edge) and advance the model.
  task automatic applyStimulus(input bit v, input bit f, input bit l,
                               input logic [W-1:0] d, output int capEdge);
    logic [LN*DW-1:0] sum;
    logic [DW-1:0]    s;
    pulse_t           pe;
    data_in       = d;
    data_in_valid = v;
    first_pass    = f;
    last_pass     = l;
    capEdge       = cyc + 1;
    if (v) begin
      sum = '0;
      for (int c = 0; c < CH; c++)
        for (int p = 0; p < LN; p++)
          sum[p*DW +: DW] += d[(c*LN+p)*DW +: DW];
      for (int p = 0; p < LN; p++) begin
        s = sum[p*DW +: DW];
        mAcc[p*DW +: DW] = (!mOpen || f) ? s : refAccAdd(mAcc[p*DW +: DW], s);
      end
      mOpen = 1'b1;
      if (l) begin
        pe.cyc = capEdge + S;
        pe.val = mAcc;
        expQ.push_back(pe);
        mOpen = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    int e;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, e);
  endtask

  task automatic doReset();
    int r;
    r = cyc + 1;
    rst           = 1'b1;
    data_in_valid = 1'b0;
    first_pass    = 1'b0;
    last_pass     = 1'b0;
    @(negedge clk);
    rst   = 1'b0;
    mOpen = 1'b0;
    mAcc  = '0;
    for (int i = expQ.size() - 1; i >= 0; i--)
      if (expQ[i].cyc >= r) expQ.delete(i);
  endtask

  function automatic logic [W-1:0] fillConst(input logic [DW-1:0] l0,
                                             input logic [DW-1:0] l1);
    logic [W-1:0] d;
    for (int c = 0; c < CH; c++) begin
      d[(c*LN+0)*DW +: DW] = l0;
      d[(c*LN+1)*DW +: DW] = l1;
    end
    return d;
  endfunction

  function automatic logic [W-1:0] fillIndex();
    logic [W-1:0] d;
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < LN; p++)
        d[(c*LN+p)*DW +: DW] = DW'(c);
    return d;
  endfunction

  // Reset state, and a beat presented during reset must be dropped.
  task automatic test_reset();
    rst           = 1'b1;
    data_in       = fillConst(32'd1, 32'd1);
    data_in_valid = 1'b1;
    first_pass    = 1'b1;
    last_pass     = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (data_out !== '0) begin
      fails++;
      $display("[TB] FAIL reset_data_out: got %h, want 0", data_out);
    end
    tests++;
    if (data_out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_valid: got %b, want 0", data_out_valid);
    end
    gotQ.delete();
    expQ.delete();
    rst = 1'b0;
    idle(LAT + 3);
    tests++;
    if (gotQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL reset_beat_dropped: got %0d pulses, want 0", gotQ.size());
    end
  endtask

  task automatic test_single_pass();
    int e;
    logic [LN*DW-1:0] want;
    gotQ.delete();
    want = {32'hFFFFFFE0, 32'd32};
    applyStimulus(1'b1, 1'b1, 1'b1, fillConst(32'd1, 32'hFFFFFFFF), e);
    idle(LAT + 2);
    tests++;
    if (gotQ.size() != 1) begin
      fails++;
      $display("[TB] FAIL single_count: got %0d pulses, want 1", gotQ.size());
    end
    if (gotQ.size() > 0) begin
      tests++;
      if (gotQ[0].cyc != e + S) begin
        fails++;
        $display("[TB] FAIL single_latency: got edge %0d, want %0d", gotQ[0].cyc, e + S);
      end
      tests++;
      if (gotQ[0].val !== want) begin
        fails++;
        $display("[TB] FAIL single_value: got %h, want %h", gotQ[0].val, want);
      end
    end
    tests++;
    if (data_out !== want) begin
      fails++;
      $display("[TB] FAIL single_hold: got %h, want %h", data_out, want);
    end
  endtask

  // Three passes of channel index values, with 'gap' idle cycles between.
  task automatic test_multi_pass(input int gap);
    int e;
    logic [LN*DW-1:0] want;
    gotQ.delete();
    want = {32'd1488, 32'd1488};
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1'b1, b == 0, b == 2, fillIndex(), e);
      if (b < 2) idle(gap);
    end
    idle(LAT + 2);
    tests++;
    if (gotQ.size() != 1) begin
      fails++;
      $display("[TB] FAIL multi_count gap=%0d: got %0d pulses, want 1", gap, gotQ.size());
    end
    if (gotQ.size() > 0) begin
      tests++;
      if (gotQ[0].cyc != e + S || gotQ[0].val !== want) begin
        fails++;
        $display("[TB] FAIL multi_pulse gap=%0d: got edge %0d value %h, want edge %0d value %h",
                 gap, gotQ[0].cyc, gotQ[0].val, e + S, want);
      end
    end
  endtask

  // Groups butted directly against each other with no idle cycles.
  task automatic test_back_to_back();
    int e0, e1, e2, e3;
    int wantCyc [3];
    logic [LN*DW-1:0] wantVal [3];
    gotQ.delete();
    applyStimulus(1'b1, 1'b1, 1'b1, fillConst(32'd1, 32'd1), e0);
    applyStimulus(1'b1, 1'b1, 1'b0, fillIndex(), e1);
    applyStimulus(1'b1, 1'b0, 1'b1, fillIndex(), e2);
    applyStimulus(1'b1, 1'b1, 1'b1, fillConst(32'd1, 32'd1), e3);
    idle(LAT + 2);
    wantCyc[0] = e0 + S; wantVal[0] = {32'd32, 32'd32};
    wantCyc[1] = e2 + S; wantVal[1] = {32'd992, 32'd992};
    wantCyc[2] = e3 + S; wantVal[2] = {32'd32, 32'd32};
    tests++;
    if (gotQ.size() != 3) begin
      fails++;
      $display("[TB] FAIL b2b_count: got %0d pulses, want 3", gotQ.size());
    end
    for (int i = 0; i < 3 && i < gotQ.size(); i++) begin
      tests++;
      if (gotQ[i].cyc != wantCyc[i] || gotQ[i].val !== wantVal[i]) begin
        fails++;
        $display("[TB] FAIL b2b_pulse%0d: got edge %0d value %h, want edge %0d value %h",
                 i, gotQ[i].cyc, gotQ[i].val, wantCyc[i], wantVal[i]);
      end
    end
  endtask

  task automatic test_restart();
    int e;
    logic [LN*DW-1:0] want;
    gotQ.delete();
    want = {32'd64, 32'd64};
    applyStimulus(1'b1, 1'b1, 1'b0, fillIndex(), e);
    applyStimulus(1'b1, 1'b1, 1'b1, fillConst(32'd2, 32'd2), e);
    idle(LAT + 2);
    tests++;
    if (gotQ.size() != 1) begin
      fails++;
      $display("[TB] FAIL restart_count: got %0d pulses, want 1", gotQ.size());
    end
    if (gotQ.size() > 0) begin
      tests++;
      if (gotQ[0].cyc != e + S || gotQ[0].val !== want) begin
        fails++;
        $display("[TB] FAIL restart_pulse: got edge %0d value %h, want edge %0d value %h",
                 gotQ[0].cyc, gotQ[0].val, e + S, want);
      end
    end
  endtask

  task automatic test_overflow();
    int e;
    logic [W-1:0] d;
    logic [LN*DW-1:0] want;
    gotQ.delete();
    d = fillConst(32'd0, 32'd0);
    d[0 +: DW]  = 32'h7FFFFFFF;
    d[DW +: DW] = 32'h7FFFFFFF;
`ifdef ACC_SAT_EN
    want = {32'h7FFFFFFF, 32'h7FFFFFFF};
`else
    want = {32'hFFFFFFFE, 32'hFFFFFFFE};
`endif
    applyStimulus(1'b1, 1'b1, 1'b0, d, e);
    applyStimulus(1'b1, 1'b0, 1'b1, d, e);
    idle(LAT + 2);
    tests++;
    if (gotQ.size() != 1) begin
      fails++;
      $display("[TB] FAIL overflow_count: got %0d pulses, want 1", gotQ.size());
    end
    if (gotQ.size() > 0) begin
      tests++;
      if (gotQ[0].val !== want) begin
        fails++;
        $display("[TB] FAIL overflow_value: got %h, want %h", gotQ[0].val, want);
      end
    end
  endtask

  task automatic test_reset_mid_group();
    int e;
    logic [LN*DW-1:0] want;
    gotQ.delete();
    want = {32'd32, 32'd32};
    applyStimulus(1'b1, 1'b1, 1'b0, fillConst(32'd5, 32'd5), e);
    applyStimulus(1'b1, 1'b1, 1'b0, fillConst(32'd5, 32'd5), e);
    doReset();
    tests++;
    if (data_out !== '0 || data_out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_clear: got data %h valid %b, want 0 0", data_out, data_out_valid);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, fillConst(32'd1, 32'd1), e);
    idle(4);
    tests++;
    if (data_out !== '0 || data_out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_quiet: got data %h valid %b, want 0 0", data_out, data_out_valid);
    end
    idle(4);
    tests++;
    if (gotQ.size() != 1) begin
      fails++;
      $display("[TB] FAIL midreset_count: got %0d pulses, want 1", gotQ.size());
    end
    if (gotQ.size() > 0) begin
      tests++;
      if (gotQ[0].cyc != e + S || gotQ[0].val !== want) begin
        fails++;
        $display("[TB] FAIL midreset_pulse: got edge %0d value %h, want edge %0d value %h",
                 gotQ[0].cyc, gotQ[0].val, e + S, want);
      end
    end
    // A complete single-pass group still inside the tree when reset hits.
    applyStimulus(1'b1, 1'b1, 1'b1, fillConst(32'd7, 32'd7), e);
    idle(2);
    gotQ.delete();
    doReset();
    idle(LAT + 2);
    tests++;
    if (gotQ.size() != 0 || data_out !== '0) begin
      fails++;
      $display("[TB] FAIL inflight_drop: got %0d pulses data %h, want 0 pulses data 0",
               gotQ.size(), data_out);
    end
  endtask

  task automatic test_random();
    int e;
    bit v, f, l;
    int mode;
    logic [W-1:0] d;
    doReset();
    gotQ.delete();
    expQ.delete();
    for (int n = 0; n < 300; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      f    = ($urandom_range(0, 3) == 0);
      l    = ($urandom_range(0, 2) == 0);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < CH*LN; k++) begin
        if (mode == 0) d[k*DW +: DW] = DW'($urandom_range(0, 63)) - 32'd32;
        else if (mode == 1) d[k*DW +: DW] = $urandom;
        else d[k*DW +: DW] = (k < 2) ? 32'($urandom_range(32'h70000000, 32'h7FFFFFFF))
                                     : DW'($urandom_range(0, 7));
      end
      applyStimulus(v, f, l, d, e);
    end
    idle(LAT + 2);
    tests++;
    if (gotQ.size() != expQ.size()) begin
      fails++;
      $display("[TB] FAIL random_count: got %0d pulses, want %0d", gotQ.size(), expQ.size());
    end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      tests++;
      if (gotQ[i].cyc != expQ[i].cyc || gotQ[i].val !== expQ[i].val) begin
        fails++;
        $display("[TB] FAIL random_pulse%0d: got edge %0d value %h, want edge %0d value %h",
                 i, gotQ[i].cyc, gotQ[i].val, expQ[i].cyc, expQ[i].val);
      end
    end
    if (expQ.size() > 0) begin
      tests++;
      if (data_out !== expQ[expQ.size()-1].val) begin
        fails++;
        $display("[TB] FAIL random_hold: got %h, want %h", data_out, expQ[expQ.size()-1].val);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    data_in       = '0;
    data_in_valid = 1'b0;
    first_pass    = 1'b0;
    last_pass     = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_pass();
    test_multi_pass(0);
    test_multi_pass(2);
    test_back_to_back();
    test_restart();
    test_overflow();
    test_reset_mid_group();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/channel_in_acc_tree.md
# channel_in_acc_tree

Parametrised, pipelined channel-reduction adder tree with multi-pass accumulation. It sums CHANNEL_IN_NUM channel partial products per picture lane in log2(CHANNEL_IN_NUM) registered stages. An accumulator stage then adds successive tree results, so layers whose input-channel count exceeds CHANNEL_IN_NUM are reduced over several beats. It sits between the multiplier array and the bias/quantisation stage of the convolution engine.

## Interface
Parameters:
- CHANNEL_IN_NUM, 32: channels reduced per beat; power of two, 2..64.
- LANE_NUM, `PICTURE_NUM: independent picture lanes.
- DATA_WIDTH, `WIDTH_DATA_OUT*2: signed two's-complement width of every value.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  CHANNEL_IN_NUM*LANE_NUM*DATA_WIDTH  channel c, lane p at bits [(c*LANE_NUM+p)*DATA_WIDTH +: DATA_WIDTH].
- data_in_valid  in  1  beat present this cycle.
- first_pass  in  1  beat opens an accumulation group; qualified by data_in_valid.
- last_pass  in  1  beat closes the group; qualified by data_in_valid.
- data_out  out  LANE_NUM*DATA_WIDTH  lane p at bits [p*DATA_WIDTH +: DATA_WIDTH].
- data_out_valid  out  1  one-cycle pulse when a group sum is presented.

## Operation
- Tree:
  - Stage s (1..S, where S = log2(CHANNEL_IN_NUM)) adds elements 2i and 2i+1 of stage s-1 per lane.
  - Each stage is registered.
  - Each add is DATA_WIDTH wide, with wrap-around and no width growth.
- valid, first_pass and last_pass travel in a shift register alongside the tree data. Data registers may load every cycle; only the flags are authoritative.
- Accumulator FSM acts on the tree output beat (tvalid, tfirst, tlast):
  - IDLE: on tvalid, acc <= tree sum and go to RUN; any tvalid opens a group even when tfirst=0.
  - RUN, tvalid & tfirst: acc <= tree sum. The partial group is discarded and the FSM stays in RUN.
  - RUN, tvalid & ~tfirst: acc <= acc + tree sum.
  - Any state, tvalid & tlast:
    - data_out <= the new accumulated value (tree sum when opening, acc+sum otherwise).
    - data_out_valid <= 1.
    - FSM goes to IDLE.
  - tfirst & tlast on the same beat forms a single-pass group.
  - No tvalid: acc holds and the state holds.
- data_out holds its last value between pulses.
- There is no backpressure. A beat is accepted on every cycle data_in_valid=1, and bubbles between passes are allowed.

## Timing
- Latency L = S+1 cycles, from the last_pass beat at the input to data_out_valid. With CHANNEL_IN_NUM=32, L=6.
- Throughput is one beat per cycle. Back-to-back groups are allowed: last_pass of one group may be followed directly by first_pass of the next beat.
- Reset:
  - Clears all flag pipeline bits, acc, data_out (0) and data_out_valid (0), and returns the FSM to IDLE.
  - Beats in flight at reset never produce output.
  - Beats applied on the reset cycle are dropped.

## Configuration
- ACC_SAT_EN defined: the accumulator add (acc + tree sum) saturates per lane to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- ACC_SAT_EN undefined: the accumulator wraps modulo 2^DATA_WIDTH.
- Tree adds wrap in both builds.

## Test plan
Settings: CHANNEL_IN_NUM=32, LANE_NUM=2, DATA_WIDTH=32.
- Single pass: every channel has lane0=1 and lane1=-1, with first&last on one beat -> 6 cycles later a single-cycle data_out_valid with lane0=32 and lane1=-32 (0xFFFFFFE0).
- Three back-to-back passes: channel c value = c in both lanes, first on beat 0 and last on beat 2 -> exactly one pulse, 6 cycles after beat 2, with both lanes = 1488.
- Bubbles: the same three passes with 2 idle cycles between each -> one pulse with 1488, 6 cycles after the last beat.
- Restart: pass A (sum 496) with first, then pass B (all channels 2, sum 64) with first&last -> one pulse, value 64.
- Overflow: two passes, each with ch0=0x7FFFFFFF and all other channels 0 -> without ACC_SAT_EN, output 0xFFFFFFFE; with ACC_SAT_EN, output 0x7FFFFFFF.
- Reset mid-group:
  - Stimulus: two passes with first only, rst held 1 cycle while they are in flight, then a first&last beat with all channels 1.
  - Response: outputs are 0 during and after reset; the only pulse carries 32 and arrives 6 cycles after the final beat.
